// File: rtl/wt_pkg.sv
// Shared constants, types and helpers for the wavelet synthesis stages.
// Coefficients are Q1.11 Daubechies-6 synthesis taps, index 0 first.
package wt_pkg;

    localparam int COEF_W    = 12;
    localparam int DB6_ORDER = 12;

    typedef logic [0:DB6_ORDER-1][COEF_W-1:0] db6_coef_t;

    localparam db6_coef_t cDB6_L = '{
        -12'sd3,    12'sd9,    12'sd1,   -12'sd65,
         12'sd56,   12'sd199, -12'sd266, -12'sd464,
         12'sd645,  12'sd1538, 12'sd1012, 12'sd228
    };

    localparam db6_coef_t cDB6_H = '{
        -12'sd229,  12'sd1012, -12'sd1539, 12'sd645,
         12'sd463, -12'sd266,  -12'sd200,  12'sd56,
         12'sd64,   12'sd1,    -12'sd10,  -12'sd3
    };

    typedef enum logic [1:0] {
        IDLE,
        PH0,
        PH1
    } poly_state_e;

    // Full-precision sum of pORDER/2 H products plus pORDER/2 L products.
    function automatic int acc_width(input int width, input int order);
        return width + COEF_W + $clog2(order);
    endfunction

endpackage

// File: rtl/wvlt_poly_fir.sv
// One channel of the polyphase synthesis filter: H/L delay lines and a
// dual MAC whose coefficient set is picked by the output phase.
module wvlt_poly_fir
    import wt_pkg::*;
#(
    parameter int pWIDTH = 16,
    parameter int pORDER = 12,
    parameter logic [0:pORDER-1][COEF_W-1:0] pCOEF_L = cDB6_L,
    parameter logic [0:pORDER-1][COEF_W-1:0] pCOEF_H = cDB6_H,
    localparam int AW = acc_width(pWIDTH, pORDER)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              shift,
    input  logic              phase,
    input  logic [pWIDTH-1:0] dat_h,
    input  logic [pWIDTH-1:0] dat_l,
    output logic [AW-1:0]     acc
);

    localparam int TAPS = pORDER / 2;
    localparam int PW   = pWIDTH + COEF_W;

    logic [TAPS-1:0][pWIDTH-1:0] dl_h_q, dl_h_d;
    logic [TAPS-1:0][pWIDTH-1:0] dl_l_q, dl_l_d;
    logic signed [AW-1:0]        acc_q, acc_d;
    logic signed [PW-1:0]        prod_h, prod_l;
    logic [COEF_W-1:0]           c_h, c_l;

    always_comb begin
        dl_h_d = dl_h_q;
        dl_l_d = dl_l_q;
        if (shift) begin
            for (int i = TAPS - 1; i > 0; i--) begin
                dl_h_d[i] = dl_h_q[i-1];
                dl_l_d[i] = dl_l_q[i-1];
            end
            dl_h_d[0] = dat_h;
            dl_l_d[0] = dat_l;
        end
    end

    // Tap m of the delay line meets coefficient 2m+phase.
    always_comb begin
        acc_d  = '0;
        prod_h = '0;
        prod_l = '0;
        c_h    = '0;
        c_l    = '0;
        for (int m = 0; m < TAPS; m++) begin
            c_h    = phase ? pCOEF_H[2*m+1] : pCOEF_H[2*m];
            c_l    = phase ? pCOEF_L[2*m+1] : pCOEF_L[2*m];
            prod_h = PW'($signed(dl_h_q[m])) * PW'($signed(c_h));
            prod_l = PW'($signed(dl_l_q[m])) * PW'($signed(c_l));
            acc_d  = acc_d + AW'(prod_h) + AW'(prod_l);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_h_q <= '0;
            dl_l_q <= '0;
            acc_q  <= '0;
        end else if (en) begin
            dl_h_q <= dl_h_d;
            dl_l_q <= dl_l_d;
            acc_q  <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/idwt_poly_stage.sv
// Inverse-DWT synthesis stage: one H/L pair per channel in, two rounded and
// saturated reconstructed samples per channel out, with overrun detection.
module idwt_poly_stage
    import wt_pkg::*;
#(
    parameter int pWIDTH    = 16,
    parameter int pCHANNELS = 2,
    parameter int pORDER    = 12,
    parameter int pOWIDTH   = 16,
    parameter int pFRAC     = 11,
    parameter logic [0:pORDER-1][COEF_W-1:0] pCOEF_L = cDB6_L,
    parameter logic [0:pORDER-1][COEF_W-1:0] pCOEF_H = cDB6_H
) (
    input  logic                               iclk,
    input  logic                               irst,
    input  logic                               iclk_ena,
    input  logic                               iena,
    input  logic [pCHANNELS-1:0][pWIDTH-1:0]   idatH,
    input  logic [pCHANNELS-1:0][pWIDTH-1:0]   idatL,
    output logic                               ordy,
    output logic                               oena,
    output logic [pCHANNELS-1:0][pOWIDTH-1:0]  odat,
    output logic [pCHANNELS-1:0]               osat,
    output logic                               oovr
);

    localparam int AW = acc_width(pWIDTH, pORDER);
    localparam int XW = AW + 1;
    localparam logic signed [XW-1:0] RND  = XW'(1) << (pFRAC - 1);
    localparam logic signed [XW-1:0] OMAX = XW'((1 << (pOWIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] OMIN = ~OMAX;

    poly_state_e                        state_q, state_d;
    logic                               accept, computing;
    logic [1:0]                         vld_pipe_q, vld_pipe_d;
    logic                               oovr_q, oovr_d;
    logic [pCHANNELS-1:0][pOWIDTH-1:0]  odat_q, odat_d;
    logic [pCHANNELS-1:0]               osat_q, osat_d;
    logic [pCHANNELS-1:0][AW-1:0]       acc;
    logic [pCHANNELS-1:0][pOWIDTH-1:0]  sat_val;
    logic [pCHANNELS-1:0]               sat_hit;

    always_comb begin
        state_d   = state_q;
        ordy      = (state_q != PH0);
        accept    = iena && ordy && iclk_ena;
        computing = (state_q == PH0) || (state_q == PH1);
        case (state_q)
            IDLE:    if (accept) state_d = PH0;
            PH0:     state_d = PH1;
            PH1:     state_d = accept ? PH0 : IDLE;
            default: state_d = IDLE;
        endcase
        // [0]: phase sum registered, [1]: rounded sample registered
        vld_pipe_d = {vld_pipe_q[0], computing};
        oovr_d     = oovr_q || (iena && !ordy && iclk_ena);
        odat_d     = odat_q;
        osat_d     = osat_q;
        if (vld_pipe_q[0]) begin
            odat_d = sat_val;
            osat_d = sat_hit;
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q    <= IDLE;
            vld_pipe_q <= '0;
            oovr_q     <= 1'b0;
            odat_q     <= '0;
            osat_q     <= '0;
        end else if (iclk_ena) begin
            state_q    <= state_d;
            vld_pipe_q <= vld_pipe_d;
            oovr_q     <= oovr_d;
            odat_q     <= odat_d;
            osat_q     <= osat_d;
        end
    end

    assign oena = vld_pipe_q[1] && iclk_ena;
    assign odat = odat_q;
    assign osat = osat_q;
    assign oovr = oovr_q;

    for (genvar c = 0; c < pCHANNELS; c++) begin : g_ch
        logic signed [XW-1:0] rnd, shr;

        wvlt_poly_fir #(
            .pWIDTH  (pWIDTH),
            .pORDER  (pORDER),
            .pCOEF_L (pCOEF_L),
            .pCOEF_H (pCOEF_H)
        ) u_fir (
            .clk   (iclk),
            .rst   (irst),
            .en    (iclk_ena),
            .shift (accept),
            .phase (state_q == PH1),
            .dat_h (idatH[c]),
            .dat_l (idatL[c]),
            .acc   (acc[c])
        );

        // One guard bit so the rounding constant can never wrap the sum.
        assign rnd        = XW'($signed(acc[c])) + RND;
        assign shr        = rnd >>> pFRAC;
        assign sat_hit[c] = (shr > OMAX) || (shr < OMIN);
        assign sat_val[c] = (shr > OMAX) ? OMAX[pOWIDTH-1:0] :
                            (shr < OMIN) ? OMIN[pOWIDTH-1:0] : shr[pOWIDTH-1:0];
    end

endmodule

// File: tb/tb_idwt_poly_stage.sv
// Scoreboard bench for idwt_poly_stage: a behavioural polyphase model queues
// expected samples on each accepted pair; a monitor pops them on every oena.
module tb_idwt_poly_stage;

    localparam int NCH  = 2;
    localparam int W    = 16;
    localparam int OW   = 16;
    localparam int TAPS = 6;
    localparam int CL [12] = '{-3, 9, 1, -65, 56, 199, -266, -464, 645, 1538, 1012, 228};
    localparam int CH [12] = '{-229, 1012, -1539, 645, 463, -266, -200, 56, 64, 1, -10, -3};

    typedef struct {
        int val [NCH];
        bit sat [NCH];
    } exp_t;

    logic                      clk, rst, clk_ena, iena;
    logic [NCH-1:0][W-1:0]     idat_h, idat_l;
    logic                      ordy, oena, oovr;
    logic [NCH-1:0][OW-1:0]    odat;
    logic [NCH-1:0]            osat;

    exp_t exp_q [$];
    int   hist_h [NCH][TAPS];
    int   hist_l [NCH][TAPS];
    bit   prev_acc, ovr_exp;
    int   errors, checks;

    idwt_poly_stage dut (
        .iclk     (clk),
        .irst     (rst),
        .iclk_ena (clk_ena),
        .iena     (iena),
        .idatH    (idat_h),
        .idatL    (idat_l),
        .ordy     (ordy),
        .oena     (oena),
        .odat     (odat),
        .osat     (osat),
        .oovr     (oovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: y[2n+p] = sum_m cH[2m+p]*H[n-m] + cL[2m+p]*L[n-m], then
    // floor((y + 1024) / 2048) clipped to the 16-bit signed range.
    task automatic model_accept(input logic [NCH-1:0][W-1:0] h, input logic [NCH-1:0][W-1:0] l);
        exp_t   e;
        longint s;
        for (int c = 0; c < NCH; c++) begin
            for (int m = TAPS - 1; m > 0; m--) begin
                hist_h[c][m] = hist_h[c][m-1];
                hist_l[c][m] = hist_l[c][m-1];
            end
            hist_h[c][0] = $signed(h[c]);
            hist_l[c][0] = $signed(l[c]);
        end
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < NCH; c++) begin
                s = 0;
                for (int m = 0; m < TAPS; m++)
                    s += longint'(CH[2*m+p]) * hist_h[c][m] + longint'(CL[2*m+p]) * hist_l[c][m];
                s = (s + 1024) >>> 11;
                e.sat[c] = 1'b0;
                if (s > 32767) begin
                    s = 32767;
                    e.sat[c] = 1'b1;
                end else if (s < -32768) begin
                    s = -32768;
                    e.sat[c] = 1'b1;
                end
                e.val[c] = int'(s);
            end
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1: drives the inputs for the coming edge. The stage
    // is busy exactly on the enabled cycle following an accept.
    task automatic step(input bit ce, input bit v,
                        input logic [NCH-1:0][W-1:0] h, input logic [NCH-1:0][W-1:0] l);
        clk_ena = ce;
        iena    = v;
        idat_h  = h;
        idat_l  = l;
        check("ordy", ordy, !prev_acc);
        check("oovr", oovr, ovr_exp);
        if (ce) begin
            if (v && !prev_acc) model_accept(h, l);
            if (v && prev_acc) ovr_exp = 1'b1;
            prev_acc = v && !prev_acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, '0);
        check("pending_after_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_oena", oena, 0);
        check("rst_ordy", ordy, 1);
        check("rst_oovr", oovr, 0);
        for (int c = 0; c < NCH; c++) begin
            check("rst_odat", odat[c], 0);
            check("rst_osat", osat[c], 0);
            for (int m = 0; m < TAPS; m++) begin
                hist_h[c][m] = 0;
                hist_l[c][m] = 0;
            end
        end
        exp_q.delete();
        prev_acc = 1'b0;
        ovr_exp  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every output pulse must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!clk_ena) check("oena_while_disabled", oena, 0);
                if (oena) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_oena: got pulse, expected none (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        for (int c = 0; c < NCH; c++) begin
                            check($sformatf("odat_ch%0d", c), longint'($signed(odat[c])), e.val[c]);
                            check($sformatf("osat_ch%0d", c), osat[c], e.sat[c]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [NCH-1:0][W-1:0] h, l, z;
        z       = '0;
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        clk_ena = 1'b0;
        iena    = 1'b0;
        idat_h  = '0;
        idat_l  = '0;
        do_reset();

        // L impulse on ch0, pairs every two cycles
        for (int k = 0; k < 6; k++) begin
            l = '0;
            if (k == 0) l[0] = 16'd2048;
            step(1'b1, 1'b1, z, l);
            step(1'b1, 1'b0, z, z);
        end
        drain();

        // ch0 L impulse alongside ch1 H impulse
        for (int k = 0; k < 6; k++) begin
            h = '0;
            l = '0;
            if (k == 0) begin
                l[0] = 16'd2048;
                h[1] = 16'd2048;
            end
            step(1'b1, 1'b1, h, l);
            step(1'b1, 1'b0, z, z);
        end
        drain();

        // Saturation with full-scale constant bands
        h = {NCH{16'h8000}};
        l = {NCH{16'h7fff}};
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, h, l);
            step(1'b1, 1'b0, z, z);
        end
        drain();

        // Overrun: two back-to-back pairs from IDLE
        h = {NCH{16'd300}};
        l = {NCH{16'd1200}};
        step(1'b1, 1'b1, h, l);
        step(1'b1, 1'b1, l, h);
        drain();
        step(1'b1, 1'b0, z, z);

        // Clock enable toggling; iena is held high while disabled
        for (int k = 0; k < 6; k++) begin
            l = '0;
            if (k == 0) l[0] = 16'd2048;
            step(1'b1, 1'b1, z, l);
            step(1'b0, 1'b1, {NCH{16'h1234}}, z);
            step(1'b1, 1'b0, z, z);
            step(1'b0, 1'b0, z, z);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, z, z);
            step(1'b0, 1'b0, z, z);
        end
        drain();

        // Reset between the phase-0 and phase-1 outputs
        h = {NCH{16'd700}};
        l = {NCH{16'hf000}};
        step(1'b1, 1'b1, h, l);
        step(1'b1, 1'b0, z, z);
        step(1'b1, 1'b0, z, z);
        @(negedge clk);
        #1;
        check("phase1_pending_at_reset", exp_q.size(), 1);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            l = '0;
            if (k == 0) l[0] = 16'd2048;
            step(1'b1, 1'b1, z, l);
            step(1'b1, 1'b0, z, z);
        end
        drain();

        // Random traffic, spacing and clock enable
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < NCH; c++) begin
                h[c] = W'($urandom);
                l[c] = W'($urandom);
                if ($urandom_range(0, 7) == 0) h[c] = 16'h8000;
                if ($urandom_range(0, 7) == 0) l[c] = 16'h7fff;
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, h, l);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idwt_poly_stage.md
# idwt_poly_stage

Parametrised inverse-DWT synthesis stage: upsample-by-2 plus high/low reconstruction filtering, done in polyphase form for an arbitrary number of channels (I/Q = 2 by default). It takes one high/low coefficient pair per channel and produces two reconstructed samples per channel, with rounding, saturation and overrun detection. Stages cascade, with one instance per decomposition level, to build a multi-level IDWT chain.

## Interface
- pWIDTH, 16: signed input sample width (both bands).
- pCHANNELS, 2: number of independent channels sharing one handshake.
- pORDER, 12: filter length; must be even.
- pOWIDTH, 16: signed output width after rounding and saturation.
- pFRAC, 11: coefficient fractional bits, removed at output.
- pCOEF_L, wt_pkg::cDB6_L: low-band synthesis coefficients, pORDER signed 12-bit values.
- pCOEF_H, wt_pkg::cDB6_H: high-band synthesis coefficients, pORDER signed 12-bit values.

Ports:
- iclk  in  1  clock.
- irst  in  1  asynchronous, active-high reset.
- iclk_ena  in  1  global clock enable; all state holds when low.
- iena  in  1  input pair valid.
- idatH  in  [pCHANNELS][pWIDTH]  high-band samples.
- idatL  in  [pCHANNELS][pWIDTH]  low-band samples.
- ordy  out  1  stage can accept an input pair this cycle.
- oena  out  1  output sample valid.
- odat  out  [pCHANNELS][pOWIDTH]  reconstructed samples.
- osat  out  [pCHANNELS]  saturation occurred on the current output, per channel.
- oovr  out  1  sticky overrun flag.

## Operation
- Per channel, keep a delay line of pORDER/2 past H and pORDER/2 past L samples. An accepted pair shifts in at position 0.
- Output index 2n+p (phase p ∈ {0,1}): y = Σ_{m=0}^{pORDER/2-1} (cH[2m+p]·H[n-m] + cL[2m+p]·L[n-m]).
- FSM states and transitions:
  - IDLE: ordy=1. Accept → PH0.
  - PH0: ordy=0. Computes phase 0. → PH1.
  - PH1: ordy=1. Computes phase 1. Accept → PH0; otherwise → IDLE.
  - Sustained throughput is one pair per 2 enabled cycles.
- Acceptance: iena && ordy && iclk_ena.
- Overrun: iena && !ordy && iclk_ena. The pair is dropped and the delay line is untouched. oovr sets and stays set until reset.
- Arithmetic widths:
  - Product width: pWIDTH+12.
  - Accumulator width: pWIDTH+12+$clog2(pORDER), full precision.
  - Round half-up: add 2^(pFRAC-1), then arithmetic shift right by pFRAC.
  - Saturate to [−2^(pOWIDTH-1), 2^(pOWIDTH-1)−1]. osat[c]=1 when clipped.
- All channels use identical coefficients and timing. Channels never interact.

## Timing
- All timing below counts enabled cycles (iclk_ena=1). When iclk_ena=0, state, outputs and delay lines hold, and oena is forced to 0.
- Pipeline: accept (delay-line update) → phase sum registered → round/saturate registered.
- Phase 0 output has oena=1 on the 3rd enabled cycle after the accept cycle. Phase 1 follows on the next enabled cycle.
- oena pulses one cycle per sample. odat and osat hold their values between pulses.
- Reset (asynchronous, any time including mid-pair):
  - FSM to IDLE; delay lines and accumulators to 0.
  - oena=0, odat=0, osat=0, oovr=0, ordy=1.
  - Samples in flight are discarded; no partial phase-1 output is emitted.
- Simultaneous accept in PH1 and phase-1 output: both proceed. The new pair's phase 0 follows phase 1 with no gap.

## Structure
- Package wt_pkg:
  - cDB6_L and cDB6_H coefficient arrays.
  - Coefficient width constant (12).
  - FSM state enum (IDLE, PH0, PH1).
  - Function computing accumulator width.
- Sub-module wvlt_poly_fir: one channel's delay lines plus a phase-selected dual MAC.
- The top level contains the FSM, handshake, overrun flag and round/saturate, with a generate loop instantiating pCHANNELS copies of wvlt_poly_fir.

## Test plan
- Impulse on the L band, defaults: ch0 idatL=2048 on the first pair, followed by 5 zero pairs spaced 2 cycles apart. The 12 ch0 outputs must be −3,9,1,−65,56,199,−266,−464,645,1538,1012,228 with osat=0.
- Independence: ch0 gets the L impulse 2048 while ch1 simultaneously gets an H impulse 2048. ch1 must output −229,1012,−1539,645,463,−266,−200,56,64,1,−10,−3, and ch0 must be unaffected.
- Saturation: constant L=32767, H=−32768 on all channels. After 6 pairs, even outputs are 32767 with osat=1 and odd outputs are −1 with osat=0.
- Overrun: iena high on 2 consecutive cycles from IDLE. The second pair is dropped, oovr=1 and stays set, and exactly 2 oena pulses follow.
- Clock enable: rerun the L-impulse test with iclk_ena toggling 1/0. The output value sequence is identical, and oena is never high while iclk_ena=0.
- Reset mid-stream: assert irst between the phase-0 and phase-1 outputs. All outputs go to 0 and ordy=1 immediately. A fresh L impulse afterwards reproduces the exact cL sequence.
